poly_eval_scheduler: RTL

Round-robin scheduler that shares one polynomial evaluator datapath (control block plus operating block, started by `inicio`) among `N_REQ` requesters. It arbitrates between requests and latches the winner's operands. It then resets and starts the evaluator, waits the evaluator's fixed latency, and returns the 16-bit result to the granted requester. It sits between the requester ports and the single evaluator instance.

---
 rtl/poly_eval_scheduler_pkg.sv | 5 +
 rtl/poly_eval_scheduler_rr_arbiter.sv | 20 ++
 rtl/poly_eval_scheduler.sv | 107 ++++++++++
 3 files changed

// File: rtl/poly_eval_scheduler_pkg.sv
// poly_sched_pkg: shared state encoding and default datapath width for the evaluator scheduler
package poly_sched_pkg;
  localparam int W_DEF = 16;
  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, WAIT, DONE} state_t;
endpackage

// File: rtl/poly_eval_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above the pointer
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_p,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_g,
  output logic          o_any
);
  assign o_any   = |i_req;
  assign o_grant = o_any ? (N'(1) << o_g) : '0;
  // scan from farthest to nearest so the nearest set bit above p wins
  always_comb begin
    o_g = '0;
    for (int k = N - 1; k >= 0; k--)
      if (i_req[(int'(i_p) + k) % N]) o_g = PW'((int'(i_p) + k) % N);
  end
endmodule

// File: rtl/poly_eval_scheduler.sv
// poly_eval_scheduler: round-robin sharing of one fixed-latency polynomial evaluator among requesters
module poly_eval_scheduler
  import poly_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int W        = W_DEF,
  parameter int EVAL_LAT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_x,
  input  logic [N_REQ*W-1:0] req_A,
  input  logic [N_REQ*W-1:0] req_B,
  input  logic [N_REQ*W-1:0] req_C,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_data,
  output logic               eval_rst,
  output logic               eval_inicio,
  output logic [W-1:0]       eval_x,
  output logic [W-1:0]       eval_A,
  output logic [W-1:0]       eval_B,
  output logic [W-1:0]       eval_C,
  input  logic [W-1:0]       eval_resultado,
  output logic               busy
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(EVAL_LAT + 1);
  state_t           r_state;
  logic [PW-1:0]    r_p, r_g, w_g;
  logic [CW-1:0]    r_cnt;
  logic [N_REQ-1:0] w_grant, r_ack, r_rsp_valid;
  logic             w_any, r_clr, r_inicio, r_busy;
  logic [W-1:0]     r_x, r_a, r_b, r_c, r_rsp_data;
  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .i_req(req),
    .i_p(r_p),
    .o_grant(w_grant),
    .o_g(w_g),
    .o_any(w_any)
  );
  assign ack         = r_ack;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign eval_rst    = rst | r_clr;
  assign eval_inicio = r_inicio;
  assign busy        = r_busy;
  assign eval_x      = r_x;
  assign eval_A      = r_a;
  assign eval_B      = r_b;
  assign eval_C      = r_c;
  // job sequencer: pulse outputs are registered one state ahead so they line up with the state they belong to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_p         <= '0;
      r_g         <= '0;
      r_cnt       <= '0;
      r_x         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= '0;
      r_ack       <= '0;
      r_clr       <= 1'b0;
      r_inicio    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_ack       <= '0;
      r_clr       <= 1'b0;
      r_inicio    <= 1'b0;
      r_rsp_valid <= '0;
      case (r_state)
        IDLE: if (w_any) begin
          r_g     <= w_g;
          r_x     <= req_x[int'(w_g)*W +: W];
          r_a     <= req_A[int'(w_g)*W +: W];
          r_b     <= req_B[int'(w_g)*W +: W];
          r_c     <= req_C[int'(w_g)*W +: W];
          r_ack   <= w_grant;
          r_clr   <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= CLEAR;
        end
        CLEAR: begin
          r_inicio <= 1'b1;
          r_state  <= LAUNCH;
        end
        LAUNCH: begin
          r_cnt   <= CW'(EVAL_LAT - 1);
          r_state <= WAIT;
        end
        WAIT: if (r_cnt == '0) r_state <= DONE; else r_cnt <= r_cnt - 1'b1;
        DONE: begin
          r_rsp_data  <= eval_resultado;
          r_rsp_valid <= N_REQ'(1) << r_g;
          r_p         <= (r_g == PW'(N_REQ - 1)) ? '0 : r_g + 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
